// File: rtl/multiport_register_file.sv
// Multiported register file with write-to-read bypass, optional hard-wired zero register,
// and a one-register-per-cycle clear sweep started by reset or by an explicit clear request.
module multiport_register_file #(
    parameter int DATA_WIDTH            = 8,
    parameter int NUMBER_OF_REGISTERS   = 256,
    parameter int NUMBER_OF_READ_PORTS  = 2,
    parameter int NUMBER_OF_WRITE_PORTS = 2,
    parameter int BYPASS_ENABLE         = 1,
    parameter int ZERO_REGISTER_ENABLE  = 0,
    localparam int ADDRESS_WIDTH        = $clog2(NUMBER_OF_REGISTERS)
) (
    input  logic                                            clock_in,
    input  logic                                            reset_in,
    input  logic                                            clear_in,
    input  logic [NUMBER_OF_WRITE_PORTS-1:0]                write_enable_in,
    input  logic [NUMBER_OF_WRITE_PORTS*ADDRESS_WIDTH-1:0]  write_register_address_in,
    input  logic [NUMBER_OF_WRITE_PORTS*DATA_WIDTH-1:0]     write_data_in,
    input  logic [NUMBER_OF_READ_PORTS*ADDRESS_WIDTH-1:0]   read_register_address_in,
    output logic [NUMBER_OF_READ_PORTS*DATA_WIDTH-1:0]      read_data_out,
    output logic                                            busy_out,
    output logic                                            clear_done_out
);

    localparam logic [ADDRESS_WIDTH-1:0] LAST_INDEX = ADDRESS_WIDTH'(NUMBER_OF_REGISTERS - 1);

    typedef enum logic [0:0] {
        IDLE,
        CLEARING
    } state_t;

    state_t                   r_state;
    state_t                   w_next_state;
    logic [ADDRESS_WIDTH-1:0] r_index;
    logic [ADDRESS_WIDTH-1:0] w_next_index;
    logic                     r_busy;
    logic                     w_next_busy;
    logic                     r_clear_done;
    logic                     w_next_clear_done;
    logic                     w_sweep_last;

    logic [DATA_WIDTH-1:0]    r_registers [NUMBER_OF_REGISTERS];

    logic [ADDRESS_WIDTH-1:0] w_write_address [NUMBER_OF_WRITE_PORTS];
    logic [DATA_WIDTH-1:0]    w_write_data    [NUMBER_OF_WRITE_PORTS];
    logic                     w_write_valid   [NUMBER_OF_WRITE_PORTS];

    assign w_sweep_last = (r_state == CLEARING) && (r_index == LAST_INDEX);

    // A write aimed at the hard-wired zero register is treated as if it was never enabled.
    for (genvar p = 0; p < NUMBER_OF_WRITE_PORTS; p++) begin : g_write_unpack
        assign w_write_address[p] = write_register_address_in[p*ADDRESS_WIDTH +: ADDRESS_WIDTH];
        assign w_write_data[p]    = write_data_in[p*DATA_WIDTH +: DATA_WIDTH];
        assign w_write_valid[p]   = write_enable_in[p] &&
                                    !((ZERO_REGISTER_ENABLE != 0) && (w_write_address[p] == '0));
    end

    always_ff @(posedge clock_in) begin
        if (reset_in) begin
            r_state      <= CLEARING;
            r_index      <= '0;
            r_busy       <= 1'b1;
            r_clear_done <= 1'b0;
        end else begin
            r_state      <= w_next_state;
            r_index      <= w_next_index;
            r_busy       <= w_next_busy;
            r_clear_done <= w_next_clear_done;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:     if (clear_in) w_next_state = CLEARING;
            CLEARING: if (w_sweep_last) w_next_state = IDLE;
            default:  w_next_state = IDLE;
        endcase
    end

    always_comb begin
        w_next_index      = r_index;
        w_next_busy       = (w_next_state == CLEARING);
        w_next_clear_done = w_sweep_last;
        case (r_state)
            IDLE:     if (clear_in) w_next_index = '0;
            CLEARING: w_next_index = r_index + ADDRESS_WIDTH'(1);
            default:  w_next_index = '0;
        endcase
    end

    // Port writes are applied in ascending order so the highest-indexed port wins a collision.
    always_ff @(posedge clock_in) begin
        if (!reset_in) begin
            if (r_state == CLEARING) begin
                r_registers[r_index] <= '0;
            end else begin
                for (int p = 0; p < NUMBER_OF_WRITE_PORTS; p++) begin
                    if (w_write_valid[p]) begin
                        r_registers[w_write_address[p]] <= w_write_data[p];
                    end
                end
            end
        end
    end

    for (genvar r = 0; r < NUMBER_OF_READ_PORTS; r++) begin : g_read
        logic [ADDRESS_WIDTH-1:0] w_read_address;
        logic [DATA_WIDTH-1:0]    w_read_value;

        assign w_read_address = read_register_address_in[r*ADDRESS_WIDTH +: ADDRESS_WIDTH];

        // Reads are forced to zero while clearing, so the not-yet-cleared array is never visible.
        always_comb begin
            w_read_value = r_registers[w_read_address];
            if (BYPASS_ENABLE != 0) begin
                for (int p = 0; p < NUMBER_OF_WRITE_PORTS; p++) begin
                    if (w_write_valid[p] && (w_write_address[p] == w_read_address)) begin
                        w_read_value = w_write_data[p];
                    end
                end
            end
            if ((ZERO_REGISTER_ENABLE != 0) && (w_read_address == '0)) begin
                w_read_value = '0;
            end
            if (r_state == CLEARING) begin
                w_read_value = '0;
            end
        end

        assign read_data_out[r*DATA_WIDTH +: DATA_WIDTH] = w_read_value;
    end

    assign busy_out       = r_busy;
    assign clear_done_out = r_clear_done;

endmodule

// File: tb/tb_multiport_register_file.sv
// Scoreboard bench for multiport_register_file: default build, a no-bypass build,
// and a zero-register build with three read ports.
module tb_multiport_register_file;

    logic clock;

    logic        aReset, aClear;
    logic [1:0]  aWe;
    logic [15:0] aWaddr, aWdata, aRaddr, aRdata;
    logic        aBusy, aDone;

    logic        bReset, bClear;
    logic [1:0]  bWe;
    logic [7:0]  bWaddr, bRaddr;
    logic [15:0] bWdata, bRdata;
    logic        bBusy, bDone;

    logic        cReset, cClear;
    logic [1:0]  cWe;
    logic [7:0]  cWaddr;
    logic [31:0] cWdata;
    logic [11:0] cRaddr;
    logic [47:0] cRdata;
    logic        cBusy, cDone;

    int compareCount;
    int mismatchCount;

    typedef struct {
        string       tag;
        logic [31:0] value;
    } expect_t;

    expect_t     sbQueue[$];
    logic [7:0]  modelA [256];
    logic [7:0]  modelB [16];
    logic [15:0] modelC [16];

    multiport_register_file dutA (
        .clock_in                  (clock),
        .reset_in                  (aReset),
        .clear_in                  (aClear),
        .write_enable_in           (aWe),
        .write_register_address_in (aWaddr),
        .write_data_in             (aWdata),
        .read_register_address_in  (aRaddr),
        .read_data_out             (aRdata),
        .busy_out                  (aBusy),
        .clear_done_out            (aDone)
    );

    multiport_register_file #(
        .NUMBER_OF_REGISTERS (16),
        .BYPASS_ENABLE       (0)
    ) dutB (
        .clock_in                  (clock),
        .reset_in                  (bReset),
        .clear_in                  (bClear),
        .write_enable_in           (bWe),
        .write_register_address_in (bWaddr),
        .write_data_in             (bWdata),
        .read_register_address_in  (bRaddr),
        .read_data_out             (bRdata),
        .busy_out                  (bBusy),
        .clear_done_out            (bDone)
    );

    multiport_register_file #(
        .DATA_WIDTH           (16),
        .NUMBER_OF_REGISTERS  (16),
        .NUMBER_OF_READ_PORTS (3),
        .ZERO_REGISTER_ENABLE (1)
    ) dutC (
        .clock_in                  (clock),
        .reset_in                  (cReset),
        .clear_in                  (cClear),
        .write_enable_in           (cWe),
        .write_register_address_in (cWaddr),
        .write_data_in             (cWdata),
        .read_register_address_in  (cRaddr),
        .read_data_out             (cRdata),
        .busy_out                  (cBusy),
        .clear_done_out            (cDone)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compareCount++;
        if (observed !== expected) begin
            mismatchCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic expectValue(input string tag, input logic [31:0] value);
        expect_t e;
        e.tag   = tag;
        e.value = value;
        sbQueue.push_back(e);
    endtask

    task automatic compareNext(input logic [31:0] observed);
        expect_t e;
        if (sbQueue.size() == 0) begin
            checkOutput("scoreboard.empty", 32'(sbQueue.size()), 32'd1);
        end else begin
            e = sbQueue.pop_front();
            checkOutput(e.tag, observed, e.value);
        end
    endtask

    task automatic nextCycle();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [7:0] expectA(input logic [7:0] ra, input logic [1:0] we,
                                           input logic [7:0] wa0, input logic [7:0] wd0,
                                           input logic [7:0] wa1, input logic [7:0] wd1);
        logic [7:0] v;
        v = modelA[ra];
        if (we[0] && wa0 == ra) v = wd0;
        if (we[1] && wa1 == ra) v = wd1;
        return v;
    endfunction

    task automatic applyStimulus(input logic [1:0] we, input logic [7:0] wa0, input logic [7:0] wd0,
                                 input logic [7:0] wa1, input logic [7:0] wd1,
                                 input logic [7:0] ra0, input logic [7:0] ra1);
        aWe    = we;
        aWaddr = {wa1, wa0};
        aWdata = {wd1, wd0};
        aRaddr = {ra1, ra0};
        expectValue("A.read0", 32'(expectA(ra0, we, wa0, wd0, wa1, wd1)));
        expectValue("A.read1", 32'(expectA(ra1, we, wa0, wd0, wa1, wd1)));
        expectValue("A.busyIdle", 32'd0);
        @(negedge clock);
        compareNext(32'(aRdata[7:0]));
        compareNext(32'(aRdata[15:8]));
        compareNext(32'(aBusy));
        nextCycle();
        if (we[0]) modelA[wa0] = wd0;
        if (we[1]) modelA[wa1] = wd1;
        aWe = 2'b00;
    endtask

    task automatic pushSweepExpect(input string prefix);
        expectValue({prefix, ".busyCycles"}, 32'd256);
        expectValue({prefix, ".donePulses"}, 32'd1);
        expectValue({prefix, ".doneAtFall"}, 32'd1);
        expectValue({prefix, ".nonZeroReads"}, 32'd0);
    endtask

    // Runs from the first cycle after a starting edge; keeps writing 0xFF to addresses 0/1 while busy.
    task automatic measureSweepA(input int clearAt, input int resetAt, output int busyCycles,
                                 output int donePulses, output int doneAtFall, output int nonZeroReads);
        int tail;
        tail         = -1;
        busyCycles   = 0;
        donePulses   = 0;
        doneAtFall   = 0;
        nonZeroReads = 0;
        aRaddr = {8'd1, 8'd0};
        aWaddr = {8'd1, 8'd0};
        aWdata = 16'hFFFF;
        for (int i = 0; i < 700; i++) begin
            if (aDone) donePulses++;
            if (aBusy) begin
                busyCycles++;
                if (aRdata !== 16'h0000) nonZeroReads++;
            end else if (tail < 0) begin
                tail       = 0;
                doneAtFall = int'(aDone);
            end
            if (tail >= 0) tail++;
            if (tail > 3) break;
            aClear = (i == clearAt);
            aReset = (i == resetAt);
            if (i == resetAt) busyCycles = 0;
            aWe = aBusy ? 2'b11 : 2'b00;
            nextCycle();
        end
        aWe    = 2'b00;
        aClear = 1'b0;
        aReset = 1'b0;
    endtask

    task automatic runSweepA(input string prefix, input int clearAt, input int resetAt);
        int busyCycles, donePulses, doneAtFall, nonZeroReads;
        pushSweepExpect(prefix);
        measureSweepA(clearAt, resetAt, busyCycles, donePulses, doneAtFall, nonZeroReads);
        compareNext(32'(busyCycles));
        compareNext(32'(donePulses));
        compareNext(32'(doneAtFall));
        compareNext(32'(nonZeroReads));
        for (int k = 0; k < 256; k++) modelA[k] = 8'h00;
    endtask

    task automatic applyStimulusB(input logic [1:0] we, input logic [3:0] wa0, input logic [7:0] wd0,
                                  input logic [3:0] wa1, input logic [7:0] wd1,
                                  input logic [3:0] ra0, input logic [3:0] ra1);
        bWe    = we;
        bWaddr = {wa1, wa0};
        bWdata = {wd1, wd0};
        bRaddr = {ra1, ra0};
        expectValue("B.read0", 32'(modelB[ra0]));
        expectValue("B.read1", 32'(modelB[ra1]));
        @(negedge clock);
        compareNext(32'(bRdata[7:0]));
        compareNext(32'(bRdata[15:8]));
        nextCycle();
        if (we[0]) modelB[wa0] = wd0;
        if (we[1]) modelB[wa1] = wd1;
        bWe = 2'b00;
    endtask

    function automatic logic [15:0] expectC(input logic [3:0] ra, input logic [1:0] we,
                                            input logic [3:0] wa0, input logic [15:0] wd0,
                                            input logic [3:0] wa1, input logic [15:0] wd1);
        logic [15:0] v;
        v = modelC[ra];
        if (we[0] && wa0 == ra) v = wd0;
        if (we[1] && wa1 == ra) v = wd1;
        if (ra == 4'd0) v = 16'h0000;
        return v;
    endfunction

    task automatic applyStimulusC(input logic [1:0] we, input logic [3:0] wa0, input logic [15:0] wd0,
                                  input logic [3:0] wa1, input logic [15:0] wd1,
                                  input logic [3:0] ra0, input logic [3:0] ra1, input logic [3:0] ra2);
        cWe    = we;
        cWaddr = {wa1, wa0};
        cWdata = {wd1, wd0};
        cRaddr = {ra2, ra1, ra0};
        expectValue("C.read0", 32'(expectC(ra0, we, wa0, wd0, wa1, wd1)));
        expectValue("C.read1", 32'(expectC(ra1, we, wa0, wd0, wa1, wd1)));
        expectValue("C.read2", 32'(expectC(ra2, we, wa0, wd0, wa1, wd1)));
        @(negedge clock);
        compareNext(32'(cRdata[15:0]));
        compareNext(32'(cRdata[31:16]));
        compareNext(32'(cRdata[47:32]));
        nextCycle();
        if (we[0] && wa0 != 4'd0) modelC[wa0] = wd0;
        if (we[1] && wa1 != 4'd0) modelC[wa1] = wd1;
        cWe = 2'b00;
    endtask

    initial begin
        int busyCycles;
        compareCount  = 0;
        mismatchCount = 0;
        {aReset, aClear, aWe, aWaddr, aWdata, aRaddr} = '0;
        {bReset, bClear, bWe, bWaddr, bWdata, bRaddr} = '0;
        {cReset, cClear, cWe, cWaddr, cWdata, cRaddr} = '0;
        repeat (2) @(posedge clock);
        #1;

        $display("[TB] default build: reset sweep");
        aRaddr = {8'd200, 8'd7};
        aReset = 1'b1;
        nextCycle();
        aReset = 1'b0;
        expectValue("A.resetBusy", 32'd1);
        expectValue("A.resetDone", 32'd0);
        expectValue("A.resetRead", 32'd0);
        compareNext(32'(aBusy));
        compareNext(32'(aDone));
        compareNext(32'(aRdata));
        runSweepA("A.reset", -1, -1);

        for (int k = 0; k < 256; k += 2) begin
            applyStimulus(2'b00, 8'd0, 8'd0, 8'd0, 8'd0, 8'(k), 8'(k + 1));
        end

        $display("[TB] default build: bypass and port priority");
        applyStimulus(2'b01, 8'd7, 8'hA5, 8'd0, 8'h00, 8'd8, 8'd7);
        applyStimulus(2'b00, 8'd0, 8'h00, 8'd0, 8'h00, 8'd7, 8'd7);
        applyStimulus(2'b11, 8'd3, 8'h11, 8'd3, 8'h22, 8'd3, 8'd3);
        applyStimulus(2'b00, 8'd0, 8'h00, 8'd0, 8'h00, 8'd3, 8'd7);
        applyStimulus(2'b11, 8'd10, 8'h5A, 8'd250, 8'hC3, 8'd250, 8'd10);
        applyStimulus(2'b00, 8'd0, 8'h00, 8'd0, 8'h00, 8'd250, 8'd10);
        repeat (40) begin
            applyStimulus(2'($urandom), 8'($urandom_range(0, 15)), 8'($urandom),
                          8'($urandom_range(0, 15)), 8'($urandom),
                          8'($urandom_range(0, 15)), 8'($urandom_range(0, 15)));
        end

        $display("[TB] default build: clear sweep with a repeated clear request");
        applyStimulus(2'b11, 8'd0, 8'hFF, 8'd1, 8'hFF, 8'd0, 8'd1);
        applyStimulus(2'b11, 8'd2, 8'hFF, 8'd3, 8'hFF, 8'd2, 8'd3);
        aClear = 1'b1;
        nextCycle();
        aClear = 1'b0;
        runSweepA("A.clear", 50, -1);
        applyStimulus(2'b00, 8'd0, 8'h00, 8'd0, 8'h00, 8'd0, 8'd1);
        applyStimulus(2'b00, 8'd0, 8'h00, 8'd0, 8'h00, 8'd2, 8'd3);

        $display("[TB] default build: reset during a sweep");
        applyStimulus(2'b01, 8'd9, 8'h3C, 8'd0, 8'h00, 8'd9, 8'd9);
        aClear = 1'b1;
        nextCycle();
        aClear = 1'b0;
        runSweepA("A.restart", -1, 99);
        applyStimulus(2'b00, 8'd0, 8'h00, 8'd0, 8'h00, 8'd9, 8'd3);

        $display("[TB] no-bypass build");
        bReset = 1'b1;
        nextCycle();
        bReset = 1'b0;
        expectValue("B.busyCycles", 32'd16);
        expectValue("B.doneAtFall", 32'd1);
        busyCycles = 0;
        for (int i = 0; i < 100; i++) begin
            if (!bBusy) break;
            busyCycles++;
            nextCycle();
        end
        compareNext(32'(busyCycles));
        compareNext(32'(bDone));
        for (int k = 0; k < 16; k++) modelB[k] = 8'h00;
        applyStimulusB(2'b01, 4'd7, 8'hA5, 4'd0, 8'h00, 4'd8, 4'd7);
        applyStimulusB(2'b01, 4'd7, 8'h3C, 4'd0, 8'h00, 4'd7, 4'd7);
        applyStimulusB(2'b00, 4'd0, 8'h00, 4'd0, 8'h00, 4'd7, 4'd7);
        applyStimulusB(2'b11, 4'd3, 8'h11, 4'd3, 8'h22, 4'd3, 4'd3);
        applyStimulusB(2'b00, 4'd0, 8'h00, 4'd0, 8'h00, 4'd3, 4'd15);

        $display("[TB] zero-register build");
        cReset = 1'b1;
        nextCycle();
        cReset = 1'b0;
        expectValue("C.busyCycles", 32'd16);
        busyCycles = 0;
        for (int i = 0; i < 100; i++) begin
            if (!cBusy) break;
            busyCycles++;
            nextCycle();
        end
        compareNext(32'(busyCycles));
        for (int k = 0; k < 16; k++) modelC[k] = 16'h0000;
        applyStimulusC(2'b01, 4'd0, 16'hBEEF, 4'd0, 16'h0000, 4'd0, 4'd0, 4'd0);
        applyStimulusC(2'b00, 4'd0, 16'h0000, 4'd0, 16'h0000, 4'd0, 4'd0, 4'd0);
        applyStimulusC(2'b10, 4'd0, 16'h0000, 4'd15, 16'hBEEF, 4'd15, 4'd15, 4'd15);
        applyStimulusC(2'b00, 4'd0, 16'h0000, 4'd0, 16'h0000, 4'd15, 4'd15, 4'd0);
        applyStimulusC(2'b11, 4'd5, 16'h1234, 4'd0, 16'hFFFF, 4'd5, 4'd0, 4'd15);
        applyStimulusC(2'b00, 4'd0, 16'h0000, 4'd0, 16'h0000, 4'd0, 4'd5, 4'd15);

        checkOutput("scoreboard.leftover", 32'(sbQueue.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end

endmodule
